mc_ctrl: RTL

Multi-cycle sequencing controller for the MIPS-subset CPU datapath. It latches the opcode/funct of the fetched instruction, steps through FETCH/DECODE/EXE/MEM/WB, and drives every datapath control line plus PC and instruction-register write strobes. This lets the combinational datapath run one instruction per 2–5 clocks, with state-gated write enables, instead of as a single-cycle machine.

---
 rtl/mc_pkg.sv | 70 +++++++
 rtl/mc_ctrl_decode.sv | 83 ++++++++
 rtl/mc_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: FSM states,
// opcode/funct values, datapath select codes and the decoded instruction class.
package mc_pkg;

    localparam logic [2:0] ST_FETCH  = 3'b000;
    localparam logic [2:0] ST_DECODE = 3'b001;
    localparam logic [2:0] ST_EXE    = 3'b010;
    localparam logic [2:0] ST_MEM    = 3'b011;
    localparam logic [2:0] ST_WB     = 3'b100;
    localparam logic [2:0] ST_HALT   = 3'b101;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_DM  = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_J    = 2'b01;
    localparam logic [1:0] JMP_JR   = 2'b10;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_ALU     = 3'd1,
        CLS_LW      = 3'd2,
        CLS_SW      = 3'd3,
        CLS_BEQ     = 3'd4,
        CLS_J       = 3'd5,
        CLS_JAL     = 3'd6,
        CLS_JR      = 3'd7
    } instr_cls_e;

    typedef struct packed {
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic [1:0] jump;
        logic [1:0] extop;
        logic [1:0] aluop;
        logic       alusrc;
        logic       branch;
    } ctrl_sel_t;

    function automatic logic cls_is_jump(input instr_cls_e cls);
        return (cls == CLS_J) || (cls == CLS_JAL) || (cls == CLS_JR);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational decode of the latched opcode/funct into an instruction class
// and the datapath select values held for the whole instruction.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output instr_cls_e cls,
    output ctrl_sel_t  sel
);

    always_comb begin
        cls = CLS_ILLEGAL;
        sel = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: begin
                        cls        = CLS_ALU;
                        sel.regdst = REGDST_RD;
                        sel.aluop  = ALU_ADD;
                    end
                    FN_SUBU: begin
                        cls        = CLS_ALU;
                        sel.regdst = REGDST_RD;
                        sel.aluop  = ALU_SUB;
                    end
                    FN_JR: begin
                        cls      = CLS_JR;
                        sel.jump = JMP_JR;
                    end
                    default: cls = CLS_ILLEGAL;
                endcase
            end
            OP_ORI: begin
                cls        = CLS_ALU;
                sel.regdst = REGDST_RT;
                sel.alusrc = 1'b1;
                sel.extop  = EXT_ZERO;
                sel.aluop  = ALU_OR;
            end
            OP_LUI: begin
                cls        = CLS_ALU;
                sel.regdst = REGDST_RT;
                sel.alusrc = 1'b1;
                sel.extop  = EXT_LUI;
                sel.aluop  = ALU_OR;
            end
            OP_LW: begin
                cls          = CLS_LW;
                sel.regdst   = REGDST_RT;
                sel.alusrc   = 1'b1;
                sel.extop    = EXT_SIGN;
                sel.aluop    = ALU_ADD;
                sel.memtoreg = MTR_DM;
            end
            OP_SW: begin
                cls        = CLS_SW;
                sel.alusrc = 1'b1;
                sel.extop  = EXT_SIGN;
                sel.aluop  = ALU_ADD;
            end
            OP_BEQ: begin
                cls        = CLS_BEQ;
                sel.extop  = EXT_SIGN;
                sel.aluop  = ALU_SUB;
                sel.branch = 1'b1;
            end
            OP_J: begin
                cls      = CLS_J;
                sel.jump = JMP_J;
            end
            OP_JAL: begin
                cls          = CLS_JAL;
                sel.jump     = JMP_J;
                sel.regdst   = REGDST_RA;
                sel.memtoreg = MTR_PC4;
            end
            default: cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle sequencing controller: state register, op latch, strobe gating
// and retired-instruction counter. Define CTRL_ILLEGAL_TRAP_EN to halt on illegal ops.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    output logic        irwr,
    output logic        pcwr,
    output logic [1:0]  regdst,
    output logic        alusrc,
    output logic [1:0]  memtoreg,
    output logic        regwe,
    output logic        memwe,
    output logic        branch,
    output logic [1:0]  jump,
    output logic [1:0]  extop,
    output logic [1:0]  aluop,
    output logic [2:0]  state,
    output logic [31:0] instret
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic        illegal
`endif
);

    logic [2:0]  state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [5:0]  funct_q, funct_d;
    logic [31:0] instret_q, instret_d;

    logic irwr_c, pcwr_c, regwe_c, memwe_c;

    instr_cls_e cls;
    ctrl_sel_t  sel;

    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[25:6];

    mc_decode u_decode (
        .op    (op_q),
        .funct (funct_q),
        .cls   (cls),
        .sel   (sel)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        funct_d = funct_q;
        irwr_c  = 1'b0;
        pcwr_c  = 1'b0;
        regwe_c = 1'b0;
        memwe_c = 1'b0;
        case (state_q)
            ST_FETCH: begin
                irwr_c  = 1'b1;
                op_d    = instr[31:26];
                funct_d = instr[5:0];
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (cls_is_jump(cls)) begin
                    pcwr_c  = 1'b1;
                    regwe_c = (cls == CLS_JAL);
                    state_d = ST_FETCH;
                end else if (cls == CLS_ILLEGAL) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_d = ST_HALT;
`else
                    // NOP: PC untouched, so the same word is refetched
                    state_d = ST_FETCH;
`endif
                end else begin
                    state_d = ST_EXE;
                end
            end
            ST_EXE: begin
                if (cls == CLS_BEQ) begin
                    pcwr_c  = 1'b1;
                    state_d = ST_FETCH;
                end else if (cls == CLS_LW || cls == CLS_SW) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (cls == CLS_SW) begin
                    memwe_c = 1'b1;
                    pcwr_c  = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                regwe_c = 1'b1;
                pcwr_c  = 1'b1;
                state_d = ST_FETCH;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            ST_HALT: state_d = ST_HALT;
`endif
            default: state_d = ST_FETCH;
        endcase
        instret_d = pcwr_c ? instret_q + 32'd1 : instret_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            op_q      <= 6'd0;
            funct_q   <= 6'd0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            funct_q   <= funct_d;
            instret_q <= instret_d;
        end
    end

    // Everything is forced low while reset is held, including FETCH's irwr.
    always_comb begin
        irwr     = irwr_c & ~rst;
        pcwr     = pcwr_c & ~rst;
        regwe    = regwe_c & ~rst;
        memwe    = memwe_c & ~rst;
        regdst   = rst ? 2'b00 : sel.regdst;
        alusrc   = sel.alusrc & ~rst;
        memtoreg = rst ? 2'b00 : sel.memtoreg;
        branch   = sel.branch & ~rst;
        jump     = rst ? 2'b00 : sel.jump;
        extop    = rst ? 2'b00 : sel.extop;
        aluop    = rst ? 2'b00 : sel.aluop;
        state    = rst ? 3'b000 : state_q;
        instret  = rst ? 32'd0 : instret_q;
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal = ~rst & (state_q == ST_HALT);
`endif

endmodule
